// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: owns the PC, issues one I_cache read at a time and
// buffers returned {pc,inst} pairs for decode, with redirect handling across a miss.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2,
  parameter logic [31:0] NOP_INST   = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        id_ready,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic [31:0] icache_req_addr,
  output logic        icache_req_valid,
  output logic        icache_req_wr,
  input  logic [31:0] icache_req_data,
  input  logic        icache_req_ready
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t          state_r;
  logic [31:0]     pc_r;
  logic [31:0]     pend_pc_r;
  logic            req_valid_r;
  logic [31:0]     fifo_pc_r   [FIFO_DEPTH];
  logic [31:0]     fifo_inst_r [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr_r;
  logic [PW-1:0]   rd_ptr_r;
  logic [CW-1:0]   count_r;

  logic [31:0]     target_pc_s;
  logic            push_s;
  logic            pop_s;
  logic            has_entry_s;
  logic            unused_redirect_bits_s;

  assign target_pc_s            = {redirect_pc[31:2], 2'b00};
  assign unused_redirect_bits_s = ^redirect_pc[1:0];
  assign has_entry_s            = (count_r != {CW{1'b0}});
  // Only a clean hit in S_REQ lands in the buffer; a redirect that cycle wins.
  assign push_s                 = (state_r == S_REQ) && icache_req_ready && !redirect_valid;
  assign pop_s                  = has_entry_s && id_ready;

  assign icache_req_addr  = pc_r;
  assign icache_req_valid = req_valid_r;
  assign icache_req_wr    = 1'b0;
  assign if_valid         = has_entry_s;

  // Decode-side view of the buffer head, NOP when empty
  always_comb begin
    if_pc   = 32'h0000_0000;
    if_inst = NOP_INST;
    if (has_entry_s) begin
      if_pc   = fifo_pc_r[rd_ptr_r];
      if_inst = fifo_inst_r[rd_ptr_r];
    end else begin
      if_pc   = 32'h0000_0000;
      if_inst = NOP_INST;
    end
  end

  // Fetch FSM: PC, pending redirect target and the registered request strobe
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= S_IDLE;
      pc_r        <= RESET_PC;
      pend_pc_r   <= RESET_PC;
      req_valid_r <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (redirect_valid) begin
            pc_r <= target_pc_s;
          end else if (count_r < CW'(FIFO_DEPTH)) begin
            state_r     <= S_REQ;
            req_valid_r <= 1'b1;
          end
        end
        S_REQ: begin
          if (icache_req_ready) begin
            pc_r        <= redirect_valid ? target_pc_s : (pc_r + 32'd4);
            state_r     <= S_IDLE;
            req_valid_r <= 1'b0;
          end else if (redirect_valid) begin
            pend_pc_r <= target_pc_s;
            state_r   <= S_DROP;
          end
        end
        S_DROP: begin
          // The in-flight read must complete before the new target can be issued.
          if (redirect_valid) begin
            pend_pc_r <= target_pc_s;
          end
          if (icache_req_ready) begin
            pc_r        <= redirect_valid ? target_pc_s : pend_pc_r;
            state_r     <= S_IDLE;
            req_valid_r <= 1'b0;
          end
        end
        default: begin
          state_r     <= S_IDLE;
          req_valid_r <= 1'b0;
        end
      endcase
    end
  end

  // Buffer storage written on a clean hit
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_pc_r[wr_ptr_r]   <= pc_r;
      fifo_inst_r[wr_ptr_r] <= icache_req_data;
    end
  end

  // Buffer pointers and occupancy; a redirect flush overrides push and pop
  always_ff @(posedge clk) begin
    if (rst || redirect_valid) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Scoreboard bench for if_fetch_unit: a behavioural I_cache answers reads with addr^KEY,
// directed tests queue hand-computed {pc,inst} pairs and a monitor checks decode output.
module tb_if_fetch_unit;

  localparam logic [31:0] KEY = 32'h1357_9BDF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0000_0000;
  logic        id_ready = 1'b0;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic [31:0] icache_req_addr;
  logic        icache_req_valid;
  logic        icache_req_wr;
  logic [31:0] icache_req_data;
  logic        icache_req_ready;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [31:0] req_log[$];
  int          tests = 0;
  int          fails = 0;
  int          lat = 1;
  int          cnt = 0;
  logic [31:0] start_addr = 32'h0000_0000;

  if_fetch_unit dut (
    .clk(clk), .rst(rst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_ready(id_ready),
    .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst),
    .icache_req_addr(icache_req_addr), .icache_req_valid(icache_req_valid),
    .icache_req_wr(icache_req_wr), .icache_req_data(icache_req_data),
    .icache_req_ready(icache_req_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [31:0] pc, input logic [31:0] inst);
    exp_t e;
    e.pc = pc;
    e.inst = inst;
    exp_q.push_back(e);
  endtask

  task automatic start_test(input int l, input logic rdy);
    rst = 1'b1;
    redirect_valid = 1'b0;
    cyc(2);
    lat = l;
    id_ready = rdy;
    req_log.delete();
  endtask

  task automatic wait_empty(input string name, input int bound);
    for (int i = 0; i < bound && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wait_ready(input string name);
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #2;
      if (icache_req_ready) break;
    end
    check(name, {31'd0, icache_req_ready}, 32'd1);
  endtask

  // Behavioural I_cache: ready pulse lat cycles after valid is first seen
  initial begin
    icache_req_ready = 1'b0;
    icache_req_data  = 32'h0000_0000;
    forever begin
      @(posedge clk);
      #1;
      icache_req_ready = 1'b0;
      if (icache_req_valid) begin
        if (cnt == 0) start_addr = icache_req_addr;
        if (cnt == lat) begin
          check("addr_held", icache_req_addr, start_addr);
          check("req_wr_zero", {31'd0, icache_req_wr}, 32'd0);
          icache_req_ready = 1'b1;
          icache_req_data  = icache_req_addr ^ KEY;
          req_log.push_back(icache_req_addr);
          cnt = 0;
        end else begin
          cnt++;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // Monitor: every accepted decode handoff must match the scoreboard head
  always @(negedge clk) begin
    if (!rst && if_valid && id_ready && !redirect_valid) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_entry: got pc %h inst %h, expected none", if_pc, if_inst);
      end else begin
        mon_e = exp_q.pop_front();
        check("fifo_pc", if_pc, mon_e.pc);
        check("fifo_inst", if_inst, mon_e.inst);
      end
    end
  end

  initial begin
    // Reset state
    cyc(2);
    @(negedge clk);
    check("rst_req_valid", {31'd0, icache_req_valid}, 32'd0);
    check("rst_req_addr", icache_req_addr, 32'h0000_0000);
    check("rst_if_valid", {31'd0, if_valid}, 32'd0);
    check("rst_if_pc", if_pc, 32'h0000_0000);
    check("rst_if_inst", if_inst, 32'h0000_0013);

    // T1 sequential hits
    start_test(1, 1'b1);
    push_exp(32'h0000_0000, 32'h1357_9BDF);
    push_exp(32'h0000_0004, 32'h1357_9BDB);
    push_exp(32'h0000_0008, 32'h1357_9BD7);
    rst = 1'b0;
    wait_ready("t1_ready_seen");
    @(posedge clk);
    @(negedge clk);
    check("t1_gap_low", {31'd0, icache_req_valid}, 32'd0);
    @(negedge clk);
    check("t1_rerequest", {31'd0, icache_req_valid}, 32'd1);
    check("t1_next_addr", icache_req_addr, 32'h0000_0004);
    wait_empty("t1_drained", 60);

    // T2 back-pressure fills the buffer
    start_test(1, 1'b0);
    push_exp(32'h0000_0000, 32'h1357_9BDF);
    push_exp(32'h0000_0004, 32'h1357_9BDB);
    push_exp(32'h0000_0008, 32'h1357_9BD7);
    rst = 1'b0;
    cyc(20);
    @(negedge clk);
    check("t2_full_no_req", {31'd0, icache_req_valid}, 32'd0);
    check("t2_head_valid", {31'd0, if_valid}, 32'd1);
    check("t2_head_pc", if_pc, 32'h0000_0000);
    check("t2_fetch_count", 32'(req_log.size()), 32'd2);
    cyc(1);
    id_ready = 1'b1;
    wait_empty("t2_drained", 60);
    check("t2_resume_addr", req_log[2], 32'h0000_0008);

    // T3 redirect during a long miss
    start_test(20, 1'b1);
    push_exp(32'h0000_0100, 32'h1357_9ADF);
    rst = 1'b0;
    cyc(5);
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0100;
    cyc(1);
    redirect_valid = 1'b0;
    @(negedge clk);
    check("t3_miss_addr", icache_req_addr, 32'h0000_0000);
    check("t3_no_entry", {31'd0, if_valid}, 32'd0);
    wait_empty("t3_drained", 150);
    check("t3_first_addr", req_log[0], 32'h0000_0000);
    check("t3_target_addr", req_log[1], 32'h0000_0100);

    // T4 misaligned redirect coincident with ready
    start_test(1, 1'b1);
    push_exp(32'h0000_0200, 32'h1357_99DF);
    rst = 1'b0;
    wait_ready("t4_ready_seen");
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0203;
    cyc(1);
    redirect_valid = 1'b0;
    wait_empty("t4_drained", 60);
    check("t4_target_addr", req_log[1], 32'h0000_0200);

    // T5 two redirects while the dropped read is outstanding
    start_test(20, 1'b1);
    push_exp(32'h0000_0080, 32'h1357_9B5F);
    rst = 1'b0;
    cyc(3);
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0040;
    cyc(1);
    redirect_valid = 1'b0;
    cyc(3);
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0080;
    cyc(1);
    redirect_valid = 1'b0;
    @(negedge clk);
    check("t5_fifo_empty", {31'd0, if_valid}, 32'd0);
    wait_empty("t5_drained", 150);
    check("t5_latest_wins", req_log[1], 32'h0000_0080);

    // T6 reset mid-request, then PC wrap
    start_test(20, 1'b1);
    rst = 1'b0;
    cyc(3);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("t6_valid_drop", {31'd0, icache_req_valid}, 32'd0);
    check("t6_if_valid", {31'd0, if_valid}, 32'd0);
    check("t6_addr_reset", icache_req_addr, 32'h0000_0000);
    lat = 1;
    req_log.delete();
    push_exp(32'hFFFF_FFFC, 32'hECA8_6423);
    push_exp(32'h0000_0000, 32'h1357_9BDF);
    cyc(1);
    rst = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    cyc(1);
    redirect_valid = 1'b0;
    wait_empty("t6_drained", 60);
    check("t6_top_addr", req_log[0], 32'hFFFF_FFFC);
    check("t6_wrap_addr", req_log[1], 32'h0000_0000);

    rst = 1'b1;
    cyc(2);
    check("leftover_expected", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
